// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: load-use / branch-on-load stalls, memory-wait freeze,
// branch/jump redirect flush, timeout flag and saturating stall/flush counters.
module hazard_detection_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  IF_ID_rs1,
   input  logic [4:0]  IF_ID_rs2,
   input  logic [4:0]  ID_EX_rd,
   input  logic        ID_EX_mem_read,
   input  logic [4:0]  EX_MEM_rd,
   input  logic        EX_MEM_mem_read,
   input  logic        EX_MEM_mem_access,
   input  logic        mem_ready,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump,
   output logic        pc_write,
   output logic        IF_ID_write,
   output logic        ID_EX_bubble,
   output logic        IF_ID_flush,
   output logic        freeze,
   output logic [1:0]  hdu_state,
   output logic        mem_timeout,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam int unsigned WAIT_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam logic [WAIT_W-1:0] WAIT_MAX     = '1;
   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_BUBBLE   = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

   logic mem_wait, load_use, br_load, hazard, redirect;

   // Hazard terms; x0 never creates a dependency.
   always_comb begin
      mem_wait = EX_MEM_mem_access & ~mem_ready;
      load_use = ID_EX_mem_read & (ID_EX_rd != 5'd0) &
                 ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2));
      br_load  = branch & EX_MEM_mem_read & (EX_MEM_rd != 5'd0) &
                 ((EX_MEM_rd == IF_ID_rs1) | (EX_MEM_rd == IF_ID_rs2));
      hazard   = load_use | br_load;
      redirect = branch_taken | jump;
   end

   // Priority decision: mem_wait > hazard stall > redirect > run.
   always_comb begin
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      IF_ID_flush  = 1'b0;
      freeze       = 1'b0;
      state_d      = ST_RUN;
      if (mem_wait) begin
         freeze      = 1'b1;
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         state_d     = ST_MEM_WAIT;
      end else if (hazard) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
         state_d      = ST_BUBBLE;
      end else if (redirect) begin
         IF_ID_flush = 1'b1;
      end
   end

   // Wait tracking, sticky timeout and saturating performance counters.
   always_comb begin
      wait_cnt_d  = '0;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (mem_wait) begin
         wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
         if (wait_cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
         end
      end
      if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (IF_ID_flush && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hdu_state   = state_q;
   assign mem_timeout = timeout_q;
   assign stall_cnt   = stall_cnt_q;
   assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus random
// stimulus compared against a behavioural priority/counter model.
module tb_hazard_detection_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [4:0]  rs1, rs2, id_ex_rd, ex_mem_rd;
   logic        id_ex_mr, ex_mem_mr, acc, ready, br, bt, jmp;
   logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, freeze;
   logic [1:0]  hdu_state;
   logic        mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_state, m_wait, m_stall, m_flush;
   bit m_to;

   hazard_detection_unit #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_rs1(rs1), .IF_ID_rs2(rs2),
      .ID_EX_rd(id_ex_rd), .ID_EX_mem_read(id_ex_mr),
      .EX_MEM_rd(ex_mem_rd), .EX_MEM_mem_read(ex_mem_mr),
      .EX_MEM_mem_access(acc), .mem_ready(ready),
      .branch(br), .branch_taken(bt), .jump(jmp),
      .pc_write(pc_write), .IF_ID_write(if_id_write),
      .ID_EX_bubble(id_ex_bubble), .IF_ID_flush(if_id_flush),
      .freeze(freeze), .hdu_state(hdu_state), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // 0 = run, 1 = hazard stall, 2 = memory wait, 3 = redirect
   function automatic int decide();
      bit mw, lu, bl;
      mw = acc && !ready;
      lu = id_ex_mr && (id_ex_rd != 0) && (id_ex_rd == rs1 || id_ex_rd == rs2);
      bl = br && ex_mem_mr && (ex_mem_rd != 0) && (ex_mem_rd == rs1 || ex_mem_rd == rs2);
      if (mw) return 2;
      if (lu || bl) return 1;
      if (bt || jmp) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
   endtask

   task automatic check_regs();
      check("hdu_state", 32'(hdu_state), 32'(m_state));
      check("mem_timeout", 32'(mem_timeout), 32'(m_to));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
   endtask

   task automatic check_all();
      int d;
      d = decide();
      check("pc_write", 32'(pc_write), 32'(d == 0 || d == 3));
      check("IF_ID_write", 32'(if_id_write), 32'(d == 0 || d == 3));
      check("ID_EX_bubble", 32'(id_ex_bubble), 32'(d == 1));
      check("IF_ID_flush", 32'(if_id_flush), 32'(d == 3));
      check("freeze", 32'(freeze), 32'(d == 2));
      check_regs();
   endtask

   // Advance one clock edge and update the model from the pre-edge inputs.
   task automatic tick();
      int d;
      d = decide();
      @(posedge clk);
      m_state = (d == 3) ? 0 : d;
      if (d == 2) begin
         if (m_wait == int'(TO) - 1) m_to = 1;
         if (m_wait < 255) m_wait++;
      end else begin
         m_wait = 0;
      end
      if ((d == 1 || d == 2) && m_stall < 65535) m_stall++;
      if (d == 3 && m_flush < 65535) m_flush++;
      #1;
   endtask

   task automatic step();
      #1;
      check_all();
      tick();
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; id_ex_rd = 0; ex_mem_rd = 0;
      id_ex_mr = 0; ex_mem_mr = 0; acc = 0; ready = 1;
      br = 0; bt = 0; jmp = 0;
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_regs();
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      #1;
      do_reset();

      // Load-use on rs2
      id_ex_mr = 1; id_ex_rd = 5; rs2 = 5;
      #1;
      check("lu_pc_write", 32'(pc_write), 32'd0);
      check("lu_bubble", 32'(id_ex_bubble), 32'd1);
      step();
      idle();
      check("lu_state", 32'(hdu_state), 32'd1);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      step();
      check("lu_back_run", 32'(hdu_state), 32'd0);

      // Branch on load: EX stage then MEM stage
      do_reset();
      br = 1; rs1 = 7; id_ex_mr = 1; id_ex_rd = 7;
      step();
      id_ex_mr = 0; id_ex_rd = 0; ex_mem_mr = 1; ex_mem_rd = 7;
      #1;
      check("bl_second_stall", 32'(pc_write), 32'd0);
      step();
      ex_mem_mr = 0; ex_mem_rd = 0;
      step();
      check("bl_state_run", 32'(hdu_state), 32'd0);
      check("bl_stall_cnt", 32'(stall_cnt), 32'd2);

      // Branch depending on non-load in MEM: forwarded, no stall
      idle();
      br = 1; rs1 = 9; ex_mem_rd = 9; id_ex_rd = 9;
      #1;
      check("fwd_no_stall", 32'(pc_write), 32'd1);
      step();

      // x0 immunity
      idle();
      id_ex_mr = 1; id_ex_rd = 0; rs1 = 0;
      #1;
      check("x0_pc_write", 32'(pc_write), 32'd1);
      step();

      // Priority: mem_wait over load-use over redirect
      idle();
      acc = 1; ready = 0; id_ex_mr = 1; id_ex_rd = 3; rs1 = 3; bt = 1;
      #1;
      check("pri_freeze", 32'(freeze), 32'd1);
      check("pri_bubble", 32'(id_ex_bubble), 32'd0);
      check("pri_flush", 32'(if_id_flush), 32'd0);
      step();
      check("pri_state", 32'(hdu_state), 32'd2);

      // Timeout at the TO-th consecutive wait
      do_reset();
      idle();
      acc = 1; ready = 0;
      for (int i = 1; i <= int'(TO); i++) begin
         step();
         check("to_flag", 32'(mem_timeout), 32'(i == int'(TO)));
      end
      ready = 1;
      for (int i = 0; i < 3; i++) step();
      check("to_sticky", 32'(mem_timeout), 32'd1);
      do_reset();
      check("to_cleared", 32'(mem_timeout), 32'd0);

      // Reset asserted mid-stall
      idle();
      id_ex_mr = 1; id_ex_rd = 4; rs2 = 4;
      step();
      step();
      do_reset();
      idle();
      step();
      check("rst_mid_state", 32'(hdu_state), 32'd0);

      // Random stimulus against the model
      for (int n = 0; n < 4000; n++) begin
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         id_ex_rd = 5'($urandom_range(0, 3));
         ex_mem_rd = 5'($urandom_range(0, 3));
         id_ex_mr = 1'($urandom_range(0, 1));
         ex_mem_mr = 1'($urandom_range(0, 1));
         acc = ($urandom_range(0, 3) != 0);
         ready = 1'($urandom_range(0, 1));
         br = 1'($urandom_range(0, 1));
         bt = ($urandom_range(0, 3) == 0);
         jmp = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) do_reset();
         step();
      end

      // Stall counter saturation
      do_reset();
      idle();
      id_ex_mr = 1; id_ex_rd = 2; rs1 = 2;
      for (int n = 0; n < 70000; n++) tick();
      check("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
      check_all();

      // Flush counter from 20 jumps
      do_reset();
      idle();
      jmp = 1;
      for (int n = 0; n < 20; n++) step();
      idle();
      #1;
      check("flush_20", 32'(flush_cnt), 32'd20);
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of consecutive memory-wait cycles before a timeout is flagged (range 1..255).
REQ-002 clk  input  1  single pipeline clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 IF_ID_rs1, IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 ID_EX_rd  input  5  destination of the instruction in EX; ID_EX_mem_read  input  1  EX instruction is a load.
REQ-006 EX_MEM_rd  input  5  destination of the instruction in MEM; EX_MEM_mem_read  input  1  MEM instruction is a load.
REQ-007 EX_MEM_mem_access  input  1  MEM instruction accesses data memory; mem_ready  input  1  data memory completes the access this cycle.
REQ-008 branch  input  1  ID holds a conditional branch; branch_taken  input  1  branch resolved taken in ID; jump  input  1  ID holds JAL/JALR.
REQ-009 pc_write  output  1  PC may update; IF_ID_write  output  1  IF/ID register may load.
REQ-010 ID_EX_bubble  output  1  zero the ID/EX control fields (insert a NOP).
REQ-011 IF_ID_flush  output  1  replace the IF/ID contents with a NOP.
REQ-012 freeze  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-013 hdu_state  output  2  registered FSM state: RUN=00, BUBBLE=01, MEM_WAIT=10; 11 is never reached.
REQ-014 mem_timeout  output  1  sticky error flag.
REQ-015 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-016 Hazard terms are computed combinationally:
- mem_wait = EX_MEM_mem_access & ~mem_ready.
- load_use = ID_EX_mem_read & (ID_EX_rd != 0) & (ID_EX_rd == IF_ID_rs1 | ID_EX_rd == IF_ID_rs2).
- br_load = branch & EX_MEM_mem_read & (EX_MEM_rd != 0) & (EX_MEM_rd == IF_ID_rs1 | EX_MEM_rd == IF_ID_rs2).
REQ-017 Priority is mem_wait > (load_use | br_load) > (branch_taken | jump) > none.
REQ-018 When mem_wait: freeze=1, pc_write=0, IF_ID_write=0, ID_EX_bubble=0, IF_ID_flush=0; the pipeline is held intact.
REQ-019 When stalling on a hazard (no mem_wait): pc_write=0, IF_ID_write=0, ID_EX_bubble=1, freeze=0, IF_ID_flush=0.
REQ-020 When redirecting (branch_taken or jump, no stall): IF_ID_flush=1, pc_write=1, IF_ID_write=1, ID_EX_bubble=0, freeze=0.
REQ-021 Otherwise pc_write=1, IF_ID_write=1, and all other control outputs are 0.
REQ-022 A branch in ID that depends on a load in EX stalls exactly 2 cycles: load_use in the first cycle, br_load in the second. A branch that depends on a load in MEM stalls exactly 1 cycle.
REQ-023 A branch that depends on a non-load instruction in EX or MEM does not stall; that case is resolved by forwarding.
REQ-024 branch_taken and jump are ignored in any cycle where a stall or mem_wait is active.
REQ-025 FSM next state is evaluated every edge from the current cycle's priority decision: MEM_WAIT if mem_wait, BUBBLE if a hazard stall, RUN otherwise. Transitions are therefore RUN/BUBBLE/MEM_WAIT to any state.
REQ-026 wait_cnt (8-bit internal counter):
- increments each cycle mem_wait=1, saturating at 255;
- clears on any cycle with mem_wait=0.
REQ-027 mem_timeout sets on the edge where mem_wait=1 and wait_cnt == TIMEOUT-1, i.e. on the TIMEOUT-th consecutive wait cycle. Once set it stays set until reset; it does not alter any other output.
REQ-028 stall_cnt increments on each cycle with pc_write=0; flush_cnt increments on each cycle with IF_ID_flush=1. Both saturate at 0xFFFF and never wrap.

Reset
REQ-029 rst_n=0 asynchronously forces hdu_state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-030 Combinational outputs follow REQ-016..REQ-021 during reset. The pipeline registers are reset separately and are outside this block.
REQ-031 Deasserting rst_n mid-stall resumes in RUN with clean counters; no stall state is retained.

Verification
REQ-032 Load-use: ID_EX_mem_read=1, ID_EX_rd=5, IF_ID_rs2=5 -> pc_write=0, ID_EX_bubble=1 for 1 cycle; next hdu_state=01; stall_cnt=1.
REQ-033 Branch-on-load: lw x7 in EX, then beq x7 in ID -> 2 consecutive stall cycles (load_use, then br_load), then RUN; stall_cnt=2.
REQ-034 x0 immunity: ID_EX_mem_read=1, ID_EX_rd=0, IF_ID_rs1=0 -> no stall, pc_write=1.
REQ-035 Priority: mem_wait, load_use and branch_taken all high in the same cycle -> freeze=1, ID_EX_bubble=0, IF_ID_flush=0, hdu_state=10.
REQ-036 Timeout with TIMEOUT=4: mem_ready held 0 for 4 cycles -> mem_timeout=1 after the 4th edge and stays 1 after mem_ready=1; rst_n pulse clears it.
REQ-037 Saturation: force 70000 stall cycles -> stall_cnt=0xFFFF; 20 taken jumps -> flush_cnt=20.
